dcsformer_host: RTL and testbench

Host-side driver for the DCSformer accelerator port. It holds one 8x16 input matrix and one 8-entry weight vector loaded by the system, and streams them to the accelerator with the i_valid/w_valid/w_ready protocol. It then captures the 8 returned 32-bit result words into a readable result buffer. It sits between the system load/readback bus and the accelerator and is the transmitting/collecting end of the accelerator interface.

---
 rtl/dcsformer_host.sv | 148 ++++++++++++++
 tb/tb_dcsformer_host.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcsformer_host.sv
// rtl/dcsformer_host.sv - host-side load/stream/collect driver for the DCSformer accelerator port
module dcsformer_host #(
  parameter int N_I     = 128,
  parameter int N_W     = 8,
  parameter int N_O     = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  input  logic [7:0]  ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        protocol_err,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        i_valid,
  output logic [7:0]  i_data,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        w_ready,
  input  logic        o_valid,
  input  logic [31:0] o_data
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int NB = N_I + N_W;

  typedef enum logic [2:0] {IDLE, SEND_I, WAIT_W, SEND_W, RECV, FIN} state_t;

  state_t        state;
  logic [7:0]    ld_buf [NB];
  logic [31:0]   res    [N_O];
  logic [6:0]    beat_cnt;
  logic [2:0]    rx_cnt;
  logic [TW-1:0] tmo_cnt;

  logic       ld_acc;
  logic       beat_acc;
  logic       prot_hit;
  logic       tmo_hit;
  logic [7:0] i_idx;
  logic [7:0] w_idx;

  // A beat coinciding with w_ready is a protocol violation and is dropped.
  always_comb begin
    ld_acc   = ld_valid && ld_ready && (ld_addr < 8'(NB));
    beat_acc = (state == RECV) && o_valid && !w_ready;
    prot_hit = (w_ready && (state != WAIT_W)) ||
               (o_valid && (state != RECV)) ||
               (o_valid && w_ready);
    tmo_hit  = (tmo_cnt + TW'(1)) == TW'(TIMEOUT);
    i_idx    = 8'(beat_cnt);
    w_idx    = 8'(N_I) + 8'(beat_cnt);
  end

  // Outputs are registered decodes of the current state, so they trail it by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      rx_cnt       <= '0;
      tmo_cnt      <= '0;
      ld_ready     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      protocol_err <= 1'b0;
      rd_data      <= '0;
      i_valid      <= 1'b0;
      i_data       <= '0;
      w_valid      <= 1'b0;
      w_data       <= '0;
      for (int i = 0; i < NB; i++) ld_buf[i] <= '0;
      for (int i = 0; i < N_O; i++) res[i] <= '0;
    end else begin
      ld_ready <= (state == IDLE);
      busy     <= (state != IDLE);
      done     <= (state == FIN);
      i_valid  <= (state == SEND_I);
      i_data   <= (state == SEND_I) ? ld_buf[i_idx] : '0;
      w_valid  <= (state == SEND_W);
      w_data   <= (state == SEND_W) ? ld_buf[w_idx] : '0;
      rd_data  <= res[rd_addr];

      if (ld_acc) ld_buf[ld_addr] <= ld_data;

      case (state)
        IDLE: begin
          if (start) begin
            state        <= SEND_I;
            beat_cnt     <= '0;
            rx_cnt       <= '0;
            timeout_err  <= 1'b0;
            protocol_err <= 1'b0;
          end
        end
        SEND_I: begin
          beat_cnt <= beat_cnt + 7'd1;
          if (beat_cnt == 7'(N_I - 1)) begin
            state    <= WAIT_W;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
          end
        end
        WAIT_W: begin
          if (w_ready) begin
            state    <= SEND_W;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        SEND_W: begin
          beat_cnt <= beat_cnt + 7'd1;
          if (beat_cnt == 7'(N_W - 1)) begin
            state   <= RECV;
            tmo_cnt <= '0;
          end
        end
        RECV: begin
          if (beat_acc) begin
            res[rx_cnt] <= o_data;
            rx_cnt      <= rx_cnt + 3'd1;
            tmo_cnt     <= '0;
            if (rx_cnt == 3'(N_O - 1)) state <= FIN;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if (prot_hit) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dcsformer_host.sv
// tb/tb_dcsformer_host.sv - randomized self-checking bench for dcsformer_host with a behavioural accelerator
module tb_dcsformer_host;
  localparam int TIMEOUT = 1024;
  localparam int NB      = 136;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid;
  logic [7:0]  ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        start;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        protocol_err;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        w_valid;
  logic [7:0]  w_data;
  logic        w_ready;
  logic        o_valid;
  logic [31:0] o_data;

  dcsformer_host #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .busy(busy), .done(done),
    .timeout_err(timeout_err), .protocol_err(protocol_err),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid), .w_data(w_data),
    .w_ready(w_ready), .o_valid(o_valid), .o_data(o_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference: what the system loaded, and the result word each slot must hold.
  logic [7:0] mdl_buf [NB];

  function automatic logic [31:0] exp_res(input int k);
    logic [31:0] s = 0;
    for (int i = 0; i < 128; i++) s += 32'(mdl_buf[i]);
    return s * 32'(mdl_buf[128 + k]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Behavioural accelerator: result[k] = weight[k] * sum of all input bytes.
  logic [7:0]  acc_in [$];
  logic [7:0]  acc_w  [$];
  logic [31:0] acc_res [8];
  logic [31:0] acc_sum;
  int acc_phase = 0, acc_cnt = 0, acc_idx = 0, acc_wdly = 2;
  bit acc_no_w = 0, inj_ov = 0;
  int t_wr = 0, t_lastov = 0;

  initial begin
    w_ready = 0; o_valid = 0; o_data = 0;
    forever begin
      @(negedge clk);
      w_ready = 0; o_valid = 0; o_data = 0;
      if (rst || done) acc_phase = 0;
      else case (acc_phase)
        0: if (i_valid) begin
             acc_in.delete(); acc_w.delete();
             acc_in.push_back(i_data);
             acc_phase = 1;
           end
        1: if (i_valid) acc_in.push_back(i_data);
           else begin acc_cnt = acc_wdly; acc_phase = 2; end
        2: if (!acc_no_w) begin
             if (acc_cnt == 0) begin w_ready = 1; t_wr = cyc + 1; acc_phase = 3; end
             else acc_cnt--;
           end
        3: if (w_valid) begin
             acc_w.push_back(w_data);
             if (acc_w.size() == 8) begin
               acc_sum = 0;
               foreach (acc_in[i]) acc_sum += 32'(acc_in[i]);
               for (int k = 0; k < 8; k++) acc_res[k] = acc_sum * 32'(acc_w[k]);
               acc_idx = 0; acc_cnt = $urandom_range(0, 3); acc_phase = 4;
             end
           end
        4: if (acc_cnt > 0) acc_cnt--;
           else begin
             o_valid = 1; o_data = acc_res[acc_idx]; acc_idx++;
             acc_cnt = $urandom_range(0, 3);
             if (acc_idx == 8) begin t_lastov = cyc + 1; acc_phase = 0; end
           end
        default: acc_phase = 0;
      endcase
      if (inj_ov) begin o_valid = 1; o_data = 32'hdeadbeef; inj_ov = 0; end
    end
  end

  // Output monitor
  int n_i, n_w, n_done, t_irise, t_ifall, t_wrise, t_done, t_bfall, t_start;
  bit overlap;
  logic p_iv = 0, p_wv = 0, p_done = 0, p_busy = 0;

  initial forever begin
    @(negedge clk);
    if (i_valid && !p_iv) t_irise = cyc;
    if (!i_valid && p_iv) t_ifall = cyc;
    if (i_valid) n_i++;
    if (w_valid && !p_wv) t_wrise = cyc;
    if (w_valid) n_w++;
    if (done && !p_done) begin n_done++; t_done = cyc; end
    if (!busy && p_busy) t_bfall = cyc;
    if (i_valid && w_valid) overlap = 1;
    p_iv = i_valid; p_wv = w_valid; p_done = done; p_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input int a, input int d);
    ld_valid = 1; ld_addr = 8'(a); ld_data = 8'(d);
    @(negedge clk);
    ld_valid = 0;
    if (a < NB) mdl_buf[a] = 8'(d);
  endtask

  task automatic load_pattern(input int mode);
    int d;
    for (int a = 0; a < NB; a++) begin
      if (mode == 0)      d = (a < 128) ? 1 : 2;
      else if (mode == 1) d = (a < 128) ? a : a - 128;
      else                d = $urandom_range(0, 255);
      load_byte(a, d);
      if ($urandom_range(0, 15) == 0) load_byte($urandom_range(136, 255), $urandom_range(0, 255));
    end
  endtask

  task automatic start_txn();
    n_i = 0; n_w = 0; n_done = 0; overlap = 0;
    t_irise = -1; t_ifall = -1; t_wrise = -1; t_done = -1; t_bfall = -1;
    start = 1; t_start = cyc + 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (n_done == 0 && n < 4000) begin @(negedge clk); n++; end
    tick(4);
    chk("done_seen", n_done, 1);
  endtask

  task automatic wait_beats(input int k);
    int n = 0;
    while (n_i < k && n < 500) begin @(negedge clk); n++; end
    chk("beat_reached", 32'(n_i >= k), 1);
  endtask

  task automatic check_stream();
    int m;
    chk("i_count", n_i, 128);
    m = 0;
    for (int i = 0; i < 128; i++) if (i >= acc_in.size() || acc_in[i] !== mdl_buf[i]) m++;
    chk("i_data_seq", m, 0);
    chk("w_count", n_w, 8);
    m = 0;
    for (int i = 0; i < 8; i++) if (i >= acc_w.size() || acc_w[i] !== mdl_buf[128 + i]) m++;
    chk("w_data_seq", m, 0);
    chk("iv_wv_overlap", 32'(overlap), 0);
    chk("i_rise_lat", t_irise - t_start, 1);
    chk("i_fall_lat", t_ifall - t_start, 129);
    chk("w_rise_lat", t_wrise - t_wr, 1);
  endtask

  task automatic check_results();
    for (int k = 0; k < 8; k++) begin
      rd_addr = 3'(k);
      @(negedge clk);
      chk($sformatf("res%0d", k), rd_data, exp_res(k));
    end
  endtask

  task automatic check_end();
    chk("done_lat", t_done - t_lastov, 1);
    chk("busy_lat", t_bfall - t_lastov, 2);
    chk("busy_idle", 32'(busy), 0);
    chk("ld_ready_idle", 32'(ld_ready), 1);
    chk("done_low", 32'(done), 0);
  endtask

  task automatic run_normal();
    acc_wdly = $urandom_range(0, 6);
    start_txn();
    wait_done();
    check_stream();
    check_end();
    check_results();
    chk("tmo_err_clean", 32'(timeout_err), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ld_ready"}, 32'(ld_ready), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_errs"}, {30'd0, timeout_err, protocol_err}, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_istream"}, {23'd0, i_valid, i_data}, 0);
    chk({tag, "_wstream"}, {23'd0, w_valid, w_data}, 0);
  endtask

  initial begin
    int n;
    rst = 1; ld_valid = 0; ld_addr = 0; ld_data = 0; start = 0; rd_addr = 0;
    for (int i = 0; i < NB; i++) mdl_buf[i] = 0;
    tick(3);
    check_reset_outputs("rst");
    rst = 0;
    tick(2);
    check_reset_outputs("post_rst");
    check_results();

    load_pattern(0);
    run_normal();
    chk("ones_res0", rd_data, 256);

    load_pattern(1);
    run_normal();
    chk("prot_err_clean", 32'(protocol_err), 0);

    for (int r = 0; r < 3; r++) begin
      load_pattern(2);
      run_normal();
    end

    // w_ready never arrives
    acc_no_w = 1;
    start_txn();
    wait_done();
    acc_no_w = 0;
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_lat", t_done - t_ifall, TIMEOUT);
    chk("tmo_w_count", n_w, 0);
    chk("tmo_i_count", n_i, 128);
    chk("tmo_prot", 32'(protocol_err), 0);
    check_results();

    // stray o_valid during the input stream
    acc_wdly = 1;
    start_txn();
    tick(2);
    chk("tmo_cleared", 32'(timeout_err), 0);
    wait_beats(30);
    inj_ov = 1;
    wait_done();
    chk("prot_err", 32'(protocol_err), 1);
    check_stream();
    check_results();

    // loads and start while busy are ignored
    load_pattern(2);
    start_txn();
    tick(2);
    chk("prot_cleared", 32'(protocol_err), 0);
    wait_beats(10);
    for (int i = 0; i < 20; i++) begin
      int a;
      a = $urandom_range(0, NB - 1);
      ld_valid = busy; ld_addr = 8'(a); ld_data = ~mdl_buf[a];
      @(negedge clk);
    end
    ld_valid = 0;
    n = 0;
    while (acc_phase != 4 && n < 500) begin @(negedge clk); n++; end
    chk("recv_reached", 32'(acc_phase), 4);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_done();
    check_stream();
    check_results();
    tick(20);
    chk("no_restart_done", n_done, 1);
    chk("no_restart_busy", 32'(busy), 0);
    run_normal();

    // reset in the middle of the input stream
    load_pattern(2);
    start_txn();
    wait_beats(60);
    rst = 1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 0;
    for (int i = 0; i < NB; i++) mdl_buf[i] = 0;
    tick(1);
    check_results();
    load_pattern(2);
    run_normal();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
